ram8_16: RTL and testbench

Eight-word by 16-bit register memory, the storage stage directly upstream of the existing 8-way 16-bit read multiplexer. The eight word registers drive that mux, and the mux output is this block's `out`. The block adds a synchronous single-port write path and a hardware clear sequencer that zeroes all eight words in a fixed 8-cycle sweep, with a `ready` flag. It is the building block for the larger RAM hierarchy.

---
 rtl/ram8_pkg.sv | 13 +
 rtl/my_mux8way16.sv | 35 +++
 rtl/ram8_16.sv | 89 ++++++++
 tb/tb_ram8_16.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ram8_pkg.sv
// Purpose: shared types and sizes for the 8x16 register memory slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram8_pkg;

  typedef shortint    word_t;
  typedef logic [2:0] addr_t;

  localparam int DEPTH = 8;

  typedef enum logic {IDLE, CLEAR} state_t;

endpackage

// File: rtl/my_mux8way16.sv
// Purpose: 8-way 16-bit read multiplexer selecting one of eight words.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows sel and inputs continuously.
module my_mux8way16
  import ram8_pkg::*;
(
  input  word_t in0,
  input  word_t in1,
  input  word_t in2,
  input  word_t in3,
  input  word_t in4,
  input  word_t in5,
  input  word_t in6,
  input  word_t in7,
  input  addr_t sel,
  output word_t out
);

  // Select one of the eight inputs by sel.
  always_comb begin
    out = in0;
    case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/ram8_16.sv
// Purpose: 8x16 register memory with single-port write and an 8-cycle clear sweep.
// Latency: reads are combinational; a write is visible right after its edge.
// Backpressure: ready=0 during the sweep; load/clr arriving then are dropped, not queued.
module ram8_16
  import ram8_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t in,
  input  addr_t address,
  input  logic  load,
  input  logic  clr,
  output word_t out,
  output logic  ready
);

  state_t           state_q, state_d;
  addr_t            cnt_q, cnt_d;
  logic [DEPTH-1:0] we;
  word_t            wdata;
  word_t            word [DEPTH];

  // Sequencer state and sweep counter; reset may land mid-sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus write-enable decode: address in IDLE (clr beats load), cnt in CLEAR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = '0;
    wdata   = in;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = 3'd0;
        end else if (load) begin
          we[address] = 1'b1;
        end
      end
      CLEAR: begin
        we[cnt_q] = 1'b1;
        wdata     = '0;
        // cnt wraps 7 -> 0 naturally as the sweep ends.
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Word storage; async reset zeroes every word so out drops to 0 without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) word[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) word[i] <= wdata;
      end
    end
  end

  assign ready = (state_q == IDLE);

  my_mux8way16 u_mux (
    .in0 (word[0]),
    .in1 (word[1]),
    .in2 (word[2]),
    .in3 (word[3]),
    .in4 (word[4]),
    .in5 (word[5]),
    .in6 (word[6]),
    .in7 (word[7]),
    .sel (address),
    .out (out)
  );

endmodule

// File: tb/tb_ram8_16.sv
module tb_ram8_16;
  import ram8_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t din;
  addr_t addr;
  logic  load;
  logic  clr;
  word_t dout;
  logic  ready;

  int checks = 0;
  int errors = 0;

  ram8_16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .address (addr),
    .load    (load),
    .clr     (clr),
    .out     (dout),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; performs one write edge and returns at the next negedge.
  task automatic write_word(input addr_t a, input logic [15:0] d);
    addr = a;
    din  = d;
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 8; i++) write_word(addr_t'(i), 16'h1111 * 16'(i + 1));
  endtask

  task automatic read_check(input string tag, input addr_t a, input logic [15:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 16'hDEAD;
    addr  = 3'd0;
    load  = 1'b1;
    clr   = 1'b1;

    // Reset held with busy inputs: every address reads 0, ready high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      read_check("rst_out", addr_t'(i), 16'h0000);
      chk("rst_ready", {15'd0, ready}, 16'd1);
    end
    load  = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Write/read all, including a no-bypass check before each edge.
    for (int i = 0; i < 8; i++) begin
      addr = addr_t'(i);
      din  = 16'h1111 * 16'(i + 1);
      load = 1'b1;
      #1;
      chk("no_bypass", dout, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      chk("wr_imm", dout, 16'h1111 * 16'(i + 1));
    end
    for (int i = 0; i < 8; i++) read_check("rd_all", addr_t'(i), 16'h1111 * 16'(i + 1));

    // Clear sweep watched on address 5.
    addr = 3'd5;
    clr  = 1'b1;
    @(posedge clk);           // edge K
    @(negedge clk);
    clr = 1'b0;
    chk("sw_ready_k", {15'd0, ready}, 16'd0);
    chk("sw_out_k", dout, 16'h6666);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sw_out", dout, (j < 6) ? 16'h6666 : 16'h0000);
      chk("sw_ready", {15'd0, ready}, (j < 8) ? 16'd0 : 16'd1);
    end
    for (int i = 0; i < 8; i++) read_check("sw_zero", addr_t'(i), 16'h0000);

    // clr beats load; a load mid-sweep is ignored.
    fill_pattern();
    addr = 3'd2;
    din  = 16'hBEEF;
    clr  = 1'b1;
    load = 1'b1;
    @(posedge clk);           // edge K
    @(negedge clk);
    clr  = 1'b0;
    load = 1'b0;
    chk("pri_hold_k", dout, 16'h3333);
    @(posedge clk);           // K+1
    @(negedge clk);
    chk("pri_hold_k1", dout, 16'h3333);
    @(posedge clk);           // K+2
    @(negedge clk);
    chk("pri_hold_k2", dout, 16'h3333);
    addr = 3'd7;
    din  = 16'h1234;
    load = 1'b1;
    @(posedge clk);           // K+3: clears word2, load dropped
    @(negedge clk);
    load = 1'b0;
    read_check("pri_w7_mid", 3'd7, 16'h8888);
    read_check("pri_w2_clr", 3'd2, 16'h0000);
    repeat (5) @(posedge clk); // K+4..K+8
    @(negedge clk);
    chk("pri_ready", {15'd0, ready}, 16'd1);
    read_check("pri_w7_end", 3'd7, 16'h0000);

    // Async reset between K+3 and K+4 of a sweep.
    fill_pattern();
    addr = 3'd6;
    clr  = 1'b1;
    @(posedge clk);           // K
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(posedge clk); // K+1..K+3
    @(negedge clk);
    chk("mid_pre", dout, 16'h7777);
    rst_n = 1'b0;
    #1;
    chk("mid_out", dout, 16'h0000);
    chk("mid_ready", {15'd0, ready}, 16'd1);
    read_check("mid_w7", 3'd7, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", {15'd0, ready}, 16'd1);
    write_word(3'd0, 16'hA5A5);
    read_check("post_wr", 3'd0, 16'hA5A5);
    read_check("post_w5", 3'd5, 16'h0000);

    // Signed extremes stored bit-exact.
    write_word(3'd3, 16'h8000);
    write_word(3'd4, 16'h7FFF);
    read_check("sgn_min", 3'd3, 16'h8000);
    read_check("sgn_max", 3'd4, 16'h7FFF);
    read_check("sgn_keep", 3'd0, 16'hA5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
